// File: rtl/centroid_accumulate.sv
// Accumulates point vectors into per-cluster sum rows held in external memory,
// and keeps a saturating per-cluster point count for the centroid divide step.
module centroid_accumulate #(
  parameter int KMAX = 32,
  parameter int CW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [5:0]    k,
  input  logic [9:0]    dim,
  input  logic          in_stb,
  input  logic [4:0]    in_index,
  output logic          in_ack,
  output logic          busy,
  output logic          clear_done,
  output logic          err,
  output logic [8:0]    pt_address,
  input  logic [31:0]   pt_data,
  output logic [13:0]   sum_address,
  input  logic [31:0]   sum_rd_data,
  output logic [31:0]   sum_wr_data,
  output logic          sum_write_enable,
  input  logic [4:0]    cnt_index,
  output logic [CW-1:0] cnt_out
);

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LATCH,
    RD_ADDR,
    RD_WAIT,
    ACCUM,
    NEXT,
    ACK,
    WAIT_LOW
  } state_t;

  state_t state;
  state_t state_nx;

  logic [5:0]    k_r;
  logic [9:0]    dim_r;
  logic [4:0]    row;
  logic [9:0]    el;
  logic          err_r;
  logic          done_r;
  logic [CW-1:0] cnt [KMAX];

  logic [9:0] dim_c;
  logic [5:0] k_c;
  logic       clr_empty;
  logic       clr_last;
  logic       clr_last_el;
  logic       hit;
  logic       last_el;

  // Out-of-range sizes are clamped to what the address fields can hold
  assign dim_c = (dim > 10'd512) ? 10'd512 : dim;
  assign k_c   = (k > 6'(KMAX)) ? 6'(KMAX) : k;

  assign clr_empty   = (k_r == 6'd0) || (dim_r == 10'd0);
  assign clr_last_el = (el == dim_r - 10'd1);
  assign clr_last    = clr_last_el && ({1'b0, row} == k_r - 6'd1);
  assign hit         = ({1'b0, row} < k_r);
  assign last_el     = (el + 10'd1 == dim_r);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_nx = CLR;
        end else if (in_stb) begin
          state_nx = LATCH;
        end
      end
      CLR: begin
        if (clr_empty || clr_last) begin
          state_nx = IDLE;
        end
      end
      LATCH: begin
        if (!hit || dim_r == 10'd0) begin
          state_nx = ACK;
        end else begin
          state_nx = RD_ADDR;
        end
      end
      RD_ADDR: state_nx = RD_WAIT;
      RD_WAIT: state_nx = ACCUM;
      ACCUM:   state_nx = NEXT;
      NEXT: begin
        if (last_el) begin
          state_nx = ACK;
        end else begin
          state_nx = RD_ADDR;
        end
      end
      ACK: state_nx = WAIT_LOW;
      WAIT_LOW: begin
        if (!in_stb) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_r    <= '0;
      dim_r  <= '0;
      row    <= '0;
      el     <= '0;
      err_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            k_r   <= k_c;
            dim_r <= dim_c;
            row   <= '0;
            el    <= '0;
            err_r <= 1'b0;
          end else if (in_stb) begin
            row   <= in_index;
            dim_r <= dim_c;
            el    <= '0;
          end
        end
        CLR: begin
          // row/el walk the cleared region, element index fastest
          if (!clr_empty) begin
            if (clr_last_el) begin
              el  <= '0;
              row <= row + 5'd1;
            end else begin
              el <= el + 10'd1;
            end
          end
          if (clr_empty || clr_last) begin
            done_r <= 1'b1;
          end
        end
        LATCH: begin
          if (!hit) begin
            err_r <= 1'b1;
          end
        end
        NEXT: el <= el + 10'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KMAX; i++) begin
        cnt[i] <= '0;
      end
    end else if (state == IDLE && clear) begin
      for (int i = 0; i < KMAX; i++) begin
        cnt[i] <= '0;
      end
    end else if (state == LATCH && hit) begin
      if (cnt[row] != '1) begin
        cnt[row] <= cnt[row] + CW'(1);
      end
    end
  end

  assign in_ack     = (state == ACK);
  assign busy       = (state != IDLE);
  assign clear_done = done_r;
  assign err        = err_r;

  // Address held from RD_ADDR through ACCUM so the RAM keeps presenting the same word
  assign pt_address  = el[8:0];
  assign sum_address = {row, el[8:0]};

  assign sum_write_enable = ((state == CLR) && !clr_empty)
                          || (state == ACCUM);
  assign sum_wr_data = (state == ACCUM) ? (sum_rd_data + pt_data)
                                        : 32'd0;

  assign cnt_out = cnt[cnt_index];

endmodule

// File: tb/tb_centroid_accumulate.sv
// Scoreboard bench for centroid_accumulate: expected sum writes and acks are
// queued by stimulus and popped by a monitor as the DUT produces them.
module tb_centroid_accumulate;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [5:0]    k;
  logic [9:0]    dim;
  logic          in_stb;
  logic [4:0]    in_index;
  logic          in_ack;
  logic          busy;
  logic          clear_done;
  logic          err;
  logic [8:0]    pt_address;
  logic [31:0]   pt_data;
  logic [13:0]   sum_address;
  logic [31:0]   sum_rd_data;
  logic [31:0]   sum_wr_data;
  logic          sum_write_enable;
  logic [4:0]    cnt_index;
  logic [CW-1:0] cnt_out;

  centroid_accumulate #(.KMAX(32), .CW(CW)) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .k(k),
    .dim(dim),
    .in_stb(in_stb),
    .in_index(in_index),
    .in_ack(in_ack),
    .busy(busy),
    .clear_done(clear_done),
    .err(err),
    .pt_address(pt_address),
    .pt_data(pt_data),
    .sum_address(sum_address),
    .sum_rd_data(sum_rd_data),
    .sum_wr_data(sum_wr_data),
    .sum_write_enable(sum_write_enable),
    .cnt_index(cnt_index),
    .cnt_out(cnt_out)
  );

  always #5 clock = ~clock;

  logic [31:0] pt_mem [512];
  logic [31:0] sum_mem [16384];
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clock) begin
    pt_data     <= pt_mem[pt_address];
    sum_rd_data <= sum_mem[sum_address];
    if (sum_write_enable) begin
      sum_mem[sum_address] <= sum_wr_data;
    end else if (pre_en) begin
      sum_mem[pre_addr] <= pre_data;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;
  typedef struct {
    int t0;
    int lat;
  } ack_t;

  wr_t  wr_q [$];
  ack_t ack_q [$];
  wr_t  we;
  ack_t ae;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && sum_write_enable) begin
      if (wr_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 sum_address, sum_wr_data);
      end else begin
        we = wr_q.pop_front();
        chk("wr_addr", 32'(sum_address), 32'(we.a));
        chk("wr_data", sum_wr_data, we.d);
      end
    end
    if (!reset && in_ack) begin
      if (ack_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_ack: got 1 expected 0");
      end else begin
        ae = ack_q.pop_front();
        if (ae.lat >= 0) begin
          chk("ack_latency", 32'(cyc - ae.t0), 32'(ae.lat));
        end
      end
    end
  end

  task automatic poke(logic [13:0] a, logic [31:0] d);
    @(negedge clock);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic chk_cnt(int idx, int exp);
    cnt_index = 5'(idx);
    #1;
    chk("count", 32'(cnt_out), 32'(exp));
  endtask

  task automatic exp_clear(int kv, int dv);
    for (int c = 0; c < kv; c++) begin
      for (int d = 0; d < dv; d++) begin
        wr_q.push_back('{14'(c * 512 + d), 32'd0});
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!clear_done && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("clear_done_seen", 32'(clear_done), 32'd1);
    @(negedge clock);
    chk("clear_done_pulse", 32'(clear_done), 32'd0);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ack && n < 3000);
    chk("ack_seen", 32'(in_ack), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic do_clear(int kv, int dv);
    @(negedge clock);
    clear = 1'b1;
    k     = 6'(kv);
    dim   = 10'(dv);
    exp_clear(kv, dv);
    @(negedge clock);
    clear = 1'b0;
    wait_done();
  endtask

  task automatic send(int idx, int dv, int lat, int hold);
    @(negedge clock);
    in_index = 5'(idx);
    dim      = 10'(dv);
    in_stb   = 1'b1;
    ack_q.push_back('{cyc, lat});
    wait_ack();
    repeat (hold) @(negedge clock);
    in_stb = 1'b0;
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    clear     = 1'b0;
    in_stb    = 1'b0;
    k         = '0;
    dim       = '0;
    in_index  = '0;
    cnt_index = '0;
    pre_en    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    pt_mem[0] = 32'd5;
    pt_mem[1] = 32'd7;
    pt_mem[2] = 32'd9;
    repeat (2) @(negedge clock);

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(in_ack), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(sum_write_enable), 32'd0);
    chk("rst_saddr", 32'(sum_address), 32'd0);
    chk("rst_paddr", 32'(pt_address), 32'd0);
    chk("rst_wdata", sum_wr_data, 32'd0);
    chk_cnt(0, 0);
    @(negedge clock);
    reset = 1'b0;

    // clear k=4 dim=3
    do_clear(4, 3);
    for (int i = 0; i < 32; i++) chk_cnt(i, 0);

    // basic accumulate into row 2
    poke(14'd1024, 32'd1);
    poke(14'd1025, 32'd1);
    poke(14'd1026, 32'd1);
    wr_q.push_back('{14'd1024, 32'd6});
    wr_q.push_back('{14'd1025, 32'd8});
    wr_q.push_back('{14'd1026, 32'd10});
    send(2, 3, 14, 0);
    chk_cnt(2, 1);
    chk("err_clean", 32'(err), 32'd0);

    // out-of-range index
    send(7, 3, 2, 0);
    chk("err_set", 32'(err), 32'd1);
    chk_cnt(2, 1);
    chk_cnt(3, 0);
    do_clear(4, 1);
    chk("err_cleared", 32'(err), 32'd0);
    chk_cnt(2, 0);

    // 32-bit wrap and count saturation
    poke(14'd512, 32'hFFFF_FFFF);
    pt_mem[0] = 32'd2;
    wr_q.push_back('{14'd512, 32'd1});
    send(1, 1, 6, 0);
    chk_cnt(1, 1);
    for (int i = 0; i < 15; i++) send(3, 0, 2, 0);
    chk_cnt(3, 15);
    send(3, 0, 2, 0);
    chk_cnt(3, 15);

    // clear and in_stb together; stb held past ack
    @(negedge clock);
    clear    = 1'b1;
    k        = 6'd4;
    dim      = 10'd1;
    in_index = 5'd0;
    in_stb   = 1'b1;
    exp_clear(4, 1);
    wr_q.push_back('{14'd0, 32'd2});
    ack_q.push_back('{cyc, -1});
    @(negedge clock);
    clear = 1'b0;
    wait_done();
    wait_ack();
    repeat (3) @(negedge clock);
    in_stb = 1'b0;
    wait_idle();
    chk_cnt(0, 1);
    chk_cnt(3, 0);

    // reset while in ACCUM
    poke(14'd512, 32'h55);
    pt_mem[1] = 32'd3;
    @(negedge clock);
    in_index = 5'd1;
    dim      = 10'd2;
    in_stb   = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!sum_write_enable && n < 50);
    chk("accum_reached", 32'(sum_write_enable), 32'd1);
    reset  = 1'b1;
    in_stb = 1'b0;
    #1;
    chk("abort_we", 32'(sum_write_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(in_ack), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk_cnt(1, 0);
    repeat (2) @(negedge clock);
    chk("abort_row", sum_mem[512], 32'h55);
    chk("abort_idle", 32'(busy), 32'd0);

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
